// File: rtl/ncc_pkg.sv
// Shared types and defaults for the NCC correlator and its peak finder.
package ncc_pkg;

  localparam int unsigned SCORE_W_DEF = 32;
  localparam int unsigned NUM_X_DEF   = 65;
  localparam int unsigned NUM_Y_DEF   = 65;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} peak_state_t;

  typedef logic signed [SCORE_W_DEF-1:0] score_t;

  localparam score_t SCORE_MOST_NEG = {1'b1, {(SCORE_W_DEF-1){1'b0}}};

  // Index width that stays legal when a dimension collapses to one placement.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xy_counter.sv
// Raster-order placement counter; x runs fastest, last flags the final placement.
module xy_counter
  import ncc_pkg::*;
#(
  parameter int unsigned NUM_X = NUM_X_DEF,
  parameter int unsigned NUM_Y = NUM_Y_DEF,
  localparam int unsigned XW = idx_w(NUM_X),
  localparam int unsigned YW = idx_w(NUM_Y)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] XMax = XW'(NUM_X - 1);
  localparam logic [YW-1:0] YMax = YW'(NUM_Y - 1);

  logic x_wrap;
  logic y_wrap;

  assign x_wrap = (x == XMax);
  assign y_wrap = (y == YMax);
  assign last   = x_wrap && y_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (x_wrap) begin
        x <= '0;
        y <= y_wrap ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ncc_peak_finder.sv
// Scans one window of NCC scores, tracks best/runner-up and reports one result record.
module ncc_peak_finder
  import ncc_pkg::*;
#(
  parameter int unsigned SCORE_W = SCORE_W_DEF,
  parameter int unsigned NUM_X = NUM_X_DEF,
  parameter int unsigned NUM_Y = NUM_Y_DEF,
  parameter logic signed [SCORE_W-1:0] MIN_SCORE = '0,
  localparam int unsigned XW = idx_w(NUM_X),
  localparam int unsigned YW = idx_w(NUM_Y)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] score,
  output logic                      score_ready,
  output logic                      busy,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [XW-1:0]             best_x,
  output logic [YW-1:0]             best_y,
  output logic signed [SCORE_W-1:0] best_score,
  output logic signed [SCORE_W-1:0] second_score,
  output logic                      found
);

  localparam logic signed [SCORE_W-1:0] MostNeg = {1'b1, {(SCORE_W-1){1'b0}}};

  peak_state_t               state;
  logic                      beat;
  logic                      beats_best;
  logic                      beats_second;
  logic signed [SCORE_W-1:0] new_best;
  logic [XW-1:0]             cur_x;
  logic [YW-1:0]             cur_y;
  logic                      cur_last;

  // score_ready is only ever high in SCAN, so it doubles as the accept qualifier.
  assign beat         = score_ready && score_valid;
  assign beats_best   = score > best_score;
  assign beats_second = score > second_score;
  assign new_best     = beats_best ? score : best_score;

  xy_counter #(
    .NUM_X (NUM_X),
    .NUM_Y (NUM_Y)
  ) u_xy (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == IDLE) && start),
    .enable (beat),
    .x      (cur_x),
    .y      (cur_y),
    .last   (cur_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      score_ready  <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      best_x       <= '0;
      best_y       <= '0;
      best_score   <= MostNeg;
      second_score <= MostNeg;
      found        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= SCAN;
            score_ready  <= 1'b1;
            busy         <= 1'b1;
            best_x       <= '0;
            best_y       <= '0;
            best_score   <= MostNeg;
            second_score <= MostNeg;
            found        <= 1'b0;
          end
        end
        SCAN: begin
          if (beat) begin
            if (beats_best) begin
              second_score <= best_score;
              best_score   <= score;
              best_x       <= cur_x;
              best_y       <= cur_y;
            end else if (beats_second) begin
              second_score <= score;
            end
            // The last beat is folded in this cycle, so found uses the merged best.
            if (cur_last) begin
              state        <= REPORT;
              score_ready  <= 1'b0;
              result_valid <= 1'b1;
              found        <= (new_best >= MIN_SCORE);
            end
          end
        end
        REPORT: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ncc_peak_finder.sv
// Directed bench for ncc_peak_finder with the default 65x65 window.
module tb_ncc_peak_finder;

  localparam int NX = 65;
  localparam int NY = 65;
  localparam int N  = NX * NY;
  localparam logic signed [31:0] MOST_NEG = 32'sh8000_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               score_valid;
  logic signed [31:0] score;
  logic               score_ready;
  logic               busy;
  logic               result_valid;
  logic               result_ready;
  logic [6:0]         best_x;
  logic [6:0]         best_y;
  logic signed [31:0] best_score;
  logic signed [31:0] second_score;
  logic               found;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  bit abort  = 1'b0;

  always #5 clk = ~clk;

  ncc_peak_finder dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .score_valid  (score_valid),
    .score        (score),
    .score_ready  (score_ready),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .best_x       (best_x),
    .best_y       (best_y),
    .best_score   (best_score),
    .second_score (second_score),
    .found        (found)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] pat(input int p, input int i);
    case (p)
      1:       return (i == 70) ? 32'sd500 : 32'sd0;
      2:       return -32'sd10;
      3:       return (i == 3 || i == 137) ? 32'sd300 : 32'sd100;
      4:       return (i == 2000) ? 32'sd777 : (i == 10) ? 32'sd600 : -i;
      5:       return (i == N - 1) ? 32'sd1000 : 32'sd0;
      6:       return (i == 100) ? -32'sd1 : -32'sd5;
      default: return 32'sd0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [31:0] v);
    bit rdy;
    int n;
    n = 0;
    score_valid = 1'b1;
    score = v;
    do begin
      rdy = score_ready;
      cyc();
      n++;
    end while (!rdy && n < 50);
    score_valid = 1'b0;
    if (!rdy) begin
      chk("beat_accept_timeout", rdy, 1);
      abort = 1'b1;
    end
  endtask

  task automatic stream(input int p, input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi && !abort; i++) begin
      if (gaps && $urandom_range(1) == 1) begin
        score_valid = 1'b0;
        cyc();
      end
      send(pat(p, i));
    end
  endtask

  task automatic start_search();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", score_ready, 1);
  endtask

  task automatic finish_stream(input int p, input bit gaps, input int lo);
    stream(p, lo, N - 2, gaps);
    chk("rv_before_last", result_valid, 0);
    send(pat(p, N - 1));
    chk("rv_latency", result_valid, 1);
    chk("ready_low_report", score_ready, 0);
  endtask

  task automatic check_result(input string tag, input int ex, input int ey,
                              input logic signed [31:0] bs, input logic signed [31:0] ss,
                              input bit f);
    chk({tag, "_x"}, best_x, ex);
    chk({tag, "_y"}, best_y, ey);
    chk({tag, "_best"}, best_score, bs);
    chk({tag, "_second"}, second_score, ss);
    chk({tag, "_found"}, found, f);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;
    chk("rv_drop", result_valid, 0);
    chk("busy_drop", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    score_valid = 1'b0;
    score = '0;
    result_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_ready", score_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    check_result("rst", 0, 0, MOST_NEG, MOST_NEG, 0);
    rst = 1'b0;
    cyc();

    // score_valid is ignored while idle
    score_valid = 1'b1;
    score = 32'sd9999;
    repeat (3) cyc();
    chk("idle_ready", score_ready, 0);
    chk("idle_busy", busy, 0);
    score_valid = 1'b0;

    // Single peak
    start_search();
    finish_stream(1, 1'b0, 0);
    check_result("peak", 5, 1, 500, 0, 1);
    handshake();
    check_result("peak_hold", 5, 1, 500, 0, 1);

    // All below threshold
    start_search();
    finish_stream(2, 1'b0, 0);
    check_result("neg", 0, 0, -10, -10, 0);
    handshake();

    // Tied maxima keep the earliest placement
    start_search();
    finish_stream(3, 1'b0, 0);
    check_result("tie", 3, 0, 300, 300, 1);
    handshake();

    // Gappy stream, start pokes in SCAN and REPORT, stalled consumer
    start_search();
    stream(4, 0, 1999, 1'b1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("scan_start_busy", busy, 1);
    chk("scan_start_ready", score_ready, 1);
    finish_stream(4, 1'b1, 2000);
    for (int c = 0; c < 20; c++) begin
      start = (c % 3 == 0) && (c < 19);
      cyc();
      chk("stall_rv", result_valid, 1);
      chk("stall_best", best_score, 777);
      chk("stall_xy", {best_y, best_x}, {7'd30, 7'd50});
    end
    start = 1'b0;
    check_result("gap", 50, 30, 777, 600, 1);
    handshake();
    cyc();
    chk("no_restart_busy", busy, 0);

    // Reset mid-search discards the partial result
    start_search();
    stream(1, 0, 999, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", score_ready, 0);
    chk("abort_rv", result_valid, 0);
    chk("abort_best", best_score, MOST_NEG);
    cyc();
    rst = 1'b0;
    repeat (5) cyc();
    chk("abort_no_result", result_valid, 0);
    start_search();
    finish_stream(5, 1'b0, 0);
    check_result("corner", 64, 64, 1000, 0, 1);
    handshake();

    // Back-to-back searches with consumer always ready
    result_ready = 1'b1;
    start_search();
    finish_stream(1, 1'b0, 0);
    check_result("b2b_first", 5, 1, 500, 0, 1);
    cyc();
    chk("b2b_idle", busy, 0);
    start_search();
    finish_stream(6, 1'b0, 0);
    check_result("b2b_second", 35, 1, -1, -5, 0);
    cyc();
    chk("b2b_done", busy, 0);
    result_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
